// File: rtl/hall_pkg.sv
// ============================================================================
//  Module  : hall_pkg
//  Purpose : Shared Hall-sensor code definitions for the multi-channel speed
//            meter: code constants, legality test, forward/reverse successor
//            lookups and the step classification type.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package hall_pkg;

    // Hall code values (H3,H2,H1). 0 and 7 can never occur on a healthy
    // 120-degree sensor set and are treated as illegal.
    localparam logic [2:0] HALL_CODE_0 = 3'd0;
    localparam logic [2:0] HALL_CODE_1 = 3'd1;
    localparam logic [2:0] HALL_CODE_2 = 3'd2;
    localparam logic [2:0] HALL_CODE_3 = 3'd3;
    localparam logic [2:0] HALL_CODE_4 = 3'd4;
    localparam logic [2:0] HALL_CODE_5 = 3'd5;
    localparam logic [2:0] HALL_CODE_6 = 3'd6;
    localparam logic [2:0] HALL_CODE_7 = 3'd7;

    // Classification of one observed code change.
    typedef enum logic [2:0] {
        STEP_NONE    = 3'd0,   // no change, or not primed yet
        STEP_FWD     = 3'd1,   // legal forward commutation
        STEP_REV     = 3'd2,   // legal reverse commutation
        STEP_RESYNC  = 3'd3,   // illegal -> legal recovery step
        STEP_SKIP    = 3'd4,   // legal -> legal but non-adjacent
        STEP_ILLEGAL = 3'd5    // new code is illegal
    } step_t;

    function automatic logic hall_is_legal(input logic [2:0] code);
        return (code != HALL_CODE_0) && (code != HALL_CODE_7);
    endfunction

    // Forward sequence 1->3->2->6->4->5->1. Illegal codes map to 0 so they
    // never match a legal successor.
    function automatic logic [2:0] HALL_FWD_NEXT(input logic [2:0] code);
        logic [2:0] nxt;
        nxt = HALL_CODE_0;
        case (code)
            HALL_CODE_1: nxt = HALL_CODE_3;
            HALL_CODE_3: nxt = HALL_CODE_2;
            HALL_CODE_2: nxt = HALL_CODE_6;
            HALL_CODE_6: nxt = HALL_CODE_4;
            HALL_CODE_4: nxt = HALL_CODE_5;
            HALL_CODE_5: nxt = HALL_CODE_1;
            default:     nxt = HALL_CODE_0;
        endcase
        return nxt;
    endfunction

    // Reverse sequence is the inverse walk: 1->5->4->6->2->3->1.
    function automatic logic [2:0] HALL_REV_NEXT(input logic [2:0] code);
        logic [2:0] nxt;
        nxt = HALL_CODE_0;
        case (code)
            HALL_CODE_1: nxt = HALL_CODE_5;
            HALL_CODE_5: nxt = HALL_CODE_4;
            HALL_CODE_4: nxt = HALL_CODE_6;
            HALL_CODE_6: nxt = HALL_CODE_2;
            HALL_CODE_2: nxt = HALL_CODE_3;
            HALL_CODE_3: nxt = HALL_CODE_1;
            default:     nxt = HALL_CODE_0;
        endcase
        return nxt;
    endfunction

endpackage : hall_pkg

`default_nettype wire

// File: rtl/hall_channel.sv
// ============================================================================
//  Module  : hall_channel
//  Purpose : One motor channel of the Hall speed meter. Synchronises the three
//            Hall lines, classifies each code change, keeps a saturating edge
//            count and a fault flag for the current gate window, and tracks
//            rotation direction.
//  Ports   : CLK      in   system clock (posedge)
//            RST      in   asynchronous reset, active-high
//            hall     in   raw Hall lines {H3,H2,H1}
//            gate_end in   last cycle of the gate window (clears window state)
//            count    out  window edge count including this cycle's edge
//            fault    out  window fault flag including this cycle's event
//            dir      out  direction including this cycle's step (1 = fwd)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hall_channel
    import hall_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [2:0]       hall,
    input  logic             gate_end,
    output logic [CNT_W-1:0] count,
    output logic             fault,
    output logic             dir
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [2:0]       sync_q [SYNC_STAGES];
    logic [2:0]       hs;
    logic [2:0]       prev;
    logic             primed;
    logic [CNT_W-1:0] cnt;
    logic             flag;
    logic             dir_int;

    step_t            step;
    logic             count_inc;
    logic             flag_set;
    logic [CNT_W-1:0] cnt_next;
    logic             flag_next;
    logic             dir_next;

    // Synchroniser chain; all three lines move together so a clean code
    // change on the raw bus reaches hs as one change.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 3'd0;
            end
        end else begin
            sync_q[0] <= hall;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign hs = sync_q[SYNC_STAGES-1];

    always_comb begin
        step = STEP_NONE;
        if (primed && (hs != prev)) begin
            if (!hall_is_legal(hs)) begin
                step = STEP_ILLEGAL;
            end else if (!hall_is_legal(prev)) begin
                step = STEP_RESYNC;
            end else if (hs == HALL_FWD_NEXT(prev)) begin
                step = STEP_FWD;
            end else if (hs == HALL_REV_NEXT(prev)) begin
                step = STEP_REV;
            end else begin
                step = STEP_SKIP;
            end
        end
    end

    // A skipped step still represents real rotation, so it counts as an edge
    // while also raising the fault flag. An illegal code does not count.
    always_comb begin
        count_inc = 1'b0;
        flag_set  = 1'b0;
        dir_next  = dir_int;
        case (step)
            STEP_FWD: begin
                count_inc = 1'b1;
                dir_next  = 1'b1;
            end
            STEP_REV: begin
                count_inc = 1'b1;
                dir_next  = 1'b0;
            end
            STEP_RESYNC: begin
                count_inc = 1'b1;
            end
            STEP_SKIP: begin
                count_inc = 1'b1;
                flag_set  = 1'b1;
            end
            STEP_ILLEGAL: begin
                flag_set  = 1'b1;
            end
            default: begin
                count_inc = 1'b0;
            end
        endcase
    end

    assign cnt_next  = (count_inc && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;
    assign flag_next = flag | flag_set;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev    <= 3'd0;
            primed  <= 1'b0;
            cnt     <= '0;
            flag    <= 1'b0;
            dir_int <= 1'b0;
        end else begin
            prev    <= hs;
            primed  <= 1'b1;
            dir_int <= dir_next;
            if (gate_end) begin
                // The closing window takes cnt_next/flag_next through the
                // outputs below; the new window starts empty.
                cnt  <= '0;
                flag <= 1'b0;
            end else begin
                cnt  <= cnt_next;
                flag <= flag_next;
            end
        end
    end

    // Expose the values including the current cycle so an edge landing on the
    // wrap cycle is reported with the window it closes.
    assign count = cnt_next;
    assign fault = flag_next;
    assign dir   = dir_next;

endmodule : hall_channel

`default_nettype wire

// File: rtl/hall_speed_meter.sv
// ============================================================================
//  Module  : hall_speed_meter
//  Purpose : Multi-channel Hall-sensor speed/direction meter. A shared gate
//            timer defines the measurement window; each channel counts valid
//            commutation edges per window and the results are published with
//            a common one-cycle valid pulse.
//  Ports   : CLK    in   system clock (posedge)
//            RST    in   asynchronous reset, active-high
//            hall   in   raw Hall lines, ch k = hall[3k+2:3k]
//            speed  out  edges in last completed window, ch k = [CNT_W*k +: CNT_W]
//            dir    out  1 = forward, 0 = reverse (last legal step)
//            fault  out  illegal code / skipped step in last completed window
//            valid  out  one-cycle pulse when speed/dir/fault update
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hall_speed_meter
    import hall_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int GATE_CYCLES = 1300,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [3*N_CH-1:0]     hall,
    output logic [N_CH*CNT_W-1:0] speed,
    output logic [N_CH-1:0]       dir,
    output logic [N_CH-1:0]       fault,
    output logic                  valid
);

    localparam int               TMR_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);

    logic [TMR_W-1:0] timer;
    logic             gate_end;

    logic [CNT_W-1:0] ch_count [N_CH];
    logic             ch_fault [N_CH];
    logic             ch_dir   [N_CH];

    assign gate_end = (timer == TMR_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timer <= '0;
        end else if (gate_end) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            hall_channel #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_channel (
                .CLK      (CLK),
                .RST      (RST),
                .hall     (hall[3*k +: 3]),
                .gate_end (gate_end),
                .count    (ch_count[k]),
                .fault    (ch_fault[k]),
                .dir      (ch_dir[k])
            );
        end
    endgenerate

    // Output registers load on the wrap cycle, so the new results and the
    // valid pulse become visible on the same cycle and then hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            speed <= '0;
            dir   <= '0;
            fault <= '0;
            valid <= 1'b0;
        end else begin
            valid <= gate_end;
            if (gate_end) begin
                for (int k = 0; k < N_CH; k++) begin
                    speed[CNT_W*k +: CNT_W] <= ch_count[k];
                    dir[k]                  <= ch_dir[k];
                    fault[k]                <= ch_fault[k];
                end
            end
        end
    end

endmodule : hall_speed_meter

`default_nettype wire

// File: tb/tb_hall_speed_meter.sv
// ============================================================================
//  Module  : tb_hall_speed_meter
//  Purpose : Self-checking bench for hall_speed_meter. Two instances share the
//            Hall stimulus: one with 8-bit counts, one with 4-bit counts to
//            exercise saturation. A window-level model predicts every output.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hall_speed_meter;

    localparam int N_CH = 4;
    localparam int G    = 1300;
    localparam int SYNC = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  h0  = 3'd1;
    logic [2:0]  h1  = 3'd1;
    logic [2:0]  h2  = 3'd1;
    logic [2:0]  h3  = 3'd1;
    logic [11:0] hall;

    logic [31:0] speed8;
    logic [3:0]  dir8, fault8;
    logic        valid8;
    logic [15:0] speed4;
    logic [3:0]  dir4, fault4;
    logic        valid4;

    assign hall = {h3, h2, h1, h0};

    always #5 CLK = ~CLK;

    hall_speed_meter #(.N_CH(4), .CNT_W(8), .GATE_CYCLES(G), .SYNC_STAGES(SYNC)) dut8 (
        .CLK(CLK), .RST(RST), .hall(hall),
        .speed(speed8), .dir(dir8), .fault(fault8), .valid(valid8));

    hall_speed_meter #(.N_CH(4), .CNT_W(4), .GATE_CYCLES(G), .SYNC_STAGES(SYNC)) dut4 (
        .CLK(CLK), .RST(RST), .hall(hall),
        .speed(speed4), .dir(dir4), .fault(fault4), .valid(valid4));

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Position of a code on the forward wheel; -1 for illegal codes.
    logic [2:0] fwd_seq [6] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd4, 3'd5};

    function automatic int seq_pos(input logic [2:0] c);
        for (int i = 0; i < 6; i++) begin
            if (fwd_seq[i] == c) return i;
        end
        return -1;
    endfunction

    function automatic logic [2:0] wheel(input logic [2:0] c, input int delta);
        return fwd_seq[(seq_pos(c) + delta + 6) % 6];
    endfunction

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    // ------------------------------------------------------------------
    // Model: edge k (k = 1 first edge after reset) sees the raw code that was
    // sampled SYNC edges earlier; the first edge only primes. A window closes
    // on every edge k that is a multiple of G.
    // ------------------------------------------------------------------
    int         k_edge;
    logic [2:0] hist    [N_CH][SYNC];
    logic [2:0] last_hs [N_CH];
    int         m_cnt   [N_CH];
    bit         m_flg   [N_CH];
    bit         m_dir   [N_CH];
    int         e_speed [N_CH];
    bit         e_fault [N_CH];
    bit         e_dir   [N_CH];
    bit         e_valid;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            k_edge  = 0;
            e_valid = 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                for (int s = 0; s < SYNC; s++) hist[c][s] = 3'd0;
                last_hs[c] = 3'd0;
                m_cnt[c] = 0; m_flg[c] = 1'b0; m_dir[c] = 1'b0;
                e_speed[c] = 0; e_fault[c] = 1'b0; e_dir[c] = 1'b0;
            end
        end else begin
            k_edge++;
            for (int c = 0; c < N_CH; c++) begin
                logic [2:0] now;
                int pn, pp, d;
                now = hist[c][0];
                pn  = seq_pos(now);
                pp  = seq_pos(last_hs[c]);
                if (k_edge >= 2 && now != last_hs[c]) begin
                    if (pn < 0) begin
                        m_flg[c] = 1'b1;
                    end else if (pp < 0) begin
                        m_cnt[c]++;
                    end else begin
                        d = (pn - pp + 6) % 6;
                        m_cnt[c]++;
                        if (d == 1)      m_dir[c] = 1'b1;
                        else if (d == 5) m_dir[c] = 1'b0;
                        else             m_flg[c] = 1'b1;
                    end
                end
                last_hs[c] = now;
                for (int s = 0; s < SYNC - 1; s++) hist[c][s] = hist[c][s+1];
                hist[c][SYNC-1] = hall[3*c +: 3];
            end
            e_valid = (k_edge % G == 0);
            if (e_valid) begin
                for (int c = 0; c < N_CH; c++) begin
                    e_speed[c] = m_cnt[c];
                    e_fault[c] = m_flg[c];
                    e_dir[c]   = m_dir[c];
                    m_cnt[c]   = 0;
                    m_flg[c]   = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge CLK) begin
        chk("valid8", int'(valid8), int'(e_valid));
        chk("valid4", int'(valid4), int'(e_valid));
        for (int c = 0; c < N_CH; c++) begin
            chk($sformatf("speed8[%0d]", c), int'(speed8[8*c +: 8]), sat(e_speed[c], 8));
            chk($sformatf("speed4[%0d]", c), int'(speed4[4*c +: 4]), sat(e_speed[c], 4));
            chk($sformatf("dir8[%0d]", c),   int'(dir8[c]),   int'(e_dir[c]));
            chk($sformatf("dir4[%0d]", c),   int'(dir4[c]),   int'(e_dir[c]));
            chk($sformatf("fault8[%0d]", c), int'(fault8[c]), int'(e_fault[c]));
            chk($sformatf("fault4[%0d]", c), int'(fault4[c]), int'(e_fault[c]));
        end
    end

    // Background rotation: ch0 forward every 100, ch2 reverse every 50,
    // ch3 forward every 10 cycles. ch1 is driven by the directed sequence.
    int step_cyc = 0;
    always @(negedge CLK) begin
        step_cyc++;
        if (step_cyc % 100 == 0) h0 = wheel(h0, 1);
        if (step_cyc % 50 == 0)  h2 = wheel(h2, -1);
        if (step_cyc % 10 == 0)  h3 = wheel(h3, 1);
    end

    task automatic wait_valid();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!valid8 && n < 2 * G);
        if (!valid8) chk("valid_timeout", 0, 1);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_speed8", int'(speed8), 0);
        chk("rst_valid8", int'(valid8), 0);
        RST = 1'b0;

        // Steady rotation: window 1 includes the 0->code resync step,
        // later windows are exact.
        wait_valid();
        for (int w = 0; w < 2; w++) begin
            wait_valid();
            chk("lit_speed0", int'(speed8[7:0]), 13);
            chk("lit_dir0",   int'(dir8[0]), 1);
            chk("lit_fault0", int'(fault8[0]), 0);
            chk("lit_speed1", int'(speed8[15:8]), 0);
            chk("lit_speed2", int'(speed8[23:16]), 26);
            chk("lit_dir2",   int'(dir8[2]), 0);
            chk("lit_speed3_w8", int'(speed8[31:24]), 130);
            chk("lit_speed3_w4", int'(speed4[15:12]), 15);
        end

        // Illegal code 7 on ch1 mid-window: 1->7 faults, 7->1 counts.
        repeat (300) @(negedge CLK);
        h1 = 3'd7;
        repeat (20) @(negedge CLK);
        h1 = 3'd1;
        wait_valid();
        chk("ill_speed1", int'(speed8[15:8]), 1);
        chk("ill_fault1", int'(fault8[1]), 1);
        chk("ill_fault0", int'(fault8[0]), 0);
        wait_valid();
        chk("ill_next_speed1", int'(speed8[15:8]), 0);
        chk("ill_next_fault1", int'(fault8[1]), 0);

        // Skipped step 1->2 timed to reach the classifier on the wrap cycle.
        repeat (G - 3) @(negedge CLK);
        h1 = 3'd2;
        wait_valid();
        chk("wrap_speed1", int'(speed8[15:8]), 1);
        chk("wrap_fault1", int'(fault8[1]), 1);
        chk("wrap_dir1",   int'(dir8[1]), 0);
        wait_valid();
        chk("wrap_next_speed1", int'(speed8[15:8]), 0);
        chk("wrap_next_fault1", int'(fault8[1]), 0);

        // Asynchronous reset mid-window.
        repeat (500) @(negedge CLK);
        #3 RST = 1'b1;
        #1;
        chk("arst_speed8", int'(speed8), 0);
        chk("arst_speed4", int'(speed4), 0);
        chk("arst_dir8",   int'(dir8), 0);
        chk("arst_fault8", int'(fault8), 0);
        chk("arst_valid8", int'(valid8), 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!valid8 && n < 2 * G);
        chk("first_valid_latency", n, G);

        repeat (5) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_hall_speed_meter

`default_nettype wire
